// File: rtl/integrity_pkg.sv
`default_nettype none
// ============================================================================
// Module   : integrity_pkg
// Purpose  : Shared definitions for the integrity monitor: FSM state
//            encoding, fail_code values and a state-to-fail_code decode.
// Revision : 1.0 - initial release
// ============================================================================
package integrity_pkg;

    // 3-bit FSM state encoding; the numeric values are visible on the
    // monitor's state output, so they are fixed explicitly.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRACK     = 3'd1,
        PASS      = 3'd2,
        FAIL_DATA = 3'd3,
        FAIL_TO   = 3'd4
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_DATA    = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    // fail_code is a pure decode of the FSM state (not gated by env_bad).
    function automatic logic [1:0] fail_code_of(input state_e s);
        logic [1:0] fc;
        case (s)
            FAIL_DATA: fc = FC_DATA;
            FAIL_TO:   fc = FC_TIMEOUT;
            default:   fc = FC_NONE;
        endcase
        return fc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/integrity_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that stops at MAX. Synchronous clear has priority
//            over enable; used as the magic-packet latency timer.
// Ports    : clk   - clock
//            rst   - synchronous active-high reset
//            clr_i - synchronous clear to zero
//            en_i  - count enable (holds at MAX once reached)
//            cnt_o - current count
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 7,
    parameter int MAX   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/integrity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : integrity_monitor
// Purpose  : Watches the magic-packet lifecycle around the FIFO and turns the
//            scoreboard's per-cycle data_out_vld / prop_signal pair into
//            sticky pass / fail verdicts, with a bounded-latency check and an
//            environment-legality check.
// Config   : IMON_TIMEOUT_EN - when defined, a packet that has not exited by
//            the time the timer reaches TIMEOUT produces a FAIL_TO verdict.
//            When undefined, TRACK waits indefinitely.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            start, push, pop - magic-packet select and FIFO handshakes
//            full, empty      - FIFO status
//            data_out_vld     - magic packet exiting this cycle
//            prop_signal      - 1 unless exiting data mismatches
//            state            - FSM state encoding
//            pass, fail       - sticky verdicts (fail masked by env_bad)
//            fail_code        - 0 none, 1 data mismatch, 2 timeout
//            env_bad          - sticky illegal-environment flag
//            latency          - capture-to-exit cycles, frozen at verdict
// Revision : 1.0 - initial release
// ============================================================================
module integrity_monitor
    import integrity_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int TOWID   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             push,
    input  logic             pop,
    input  logic             full,
    input  logic             empty,
    input  logic             data_out_vld,
    input  logic             prop_signal,
    output logic [2:0]       state,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic             env_bad,
    output logic [TOWID-1:0] latency
);

    localparam logic [TOWID-1:0] C_TMAX = TOWID'(TIMEOUT);

    // Elaboration-time sanity limits on the configuration.
    if ((DEPTH < 1) || (TIMEOUT < 1)) begin : g_param_check
        $error("integrity_monitor: DEPTH and TIMEOUT must both be >= 1");
    end

    state_e           state_q;
    state_e           state_d;
    logic [TOWID-1:0] latency_q;
    logic [TOWID-1:0] latency_d;
    logic             env_bad_q;
    logic             env_bad_d;

    logic             w_timer_clr;
    logic             w_timer_en;
    logic [TOWID-1:0] w_timer;
    logic [TOWID-1:0] w_timer_inc;

    sat_counter #(
        .WIDTH (TOWID),
        .MAX   (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_timer_clr),
        .en_i  (w_timer_en),
        .cnt_o (w_timer)
    );

    // Latency counts the exit cycle itself, hence timer+1, clamped at TIMEOUT.
    assign w_timer_inc = (w_timer == C_TMAX) ? w_timer : (w_timer + 1'b1);

    always_comb begin
        state_d     = state_q;
        latency_d   = latency_q;
        w_timer_clr = 1'b0;
        w_timer_en  = 1'b0;
        case (state_q)
            IDLE: begin
                // Capture cycle: the magic packet enters the FIFO.
                if (start && push) begin
                    state_d     = TRACK;
                    w_timer_clr = 1'b1;
                    latency_d   = '0;
                end
            end
            TRACK: begin
                // latency follows the running count, so it is frozen at the
                // value of the exit cycle once TRACK is left.
                w_timer_en = 1'b1;
                latency_d  = w_timer_inc;
                if (data_out_vld && prop_signal) begin
                    state_d = PASS;
                end else if (data_out_vld) begin
                    state_d = FAIL_DATA;
                end else begin
`ifdef IMON_TIMEOUT_EN
                    if (w_timer == C_TMAX) begin
                        state_d = FAIL_TO;
                    end
`endif
                end
            end
            default: begin
                // Terminal verdicts hold until reset.
            end
        endcase
    end

    // Push into a full FIFO (unless a pop frees a slot) or pop from an empty
    // FIFO is an illegal stimulus; the flag is independent of FSM state.
    assign env_bad_d = env_bad_q | (push & full & ~pop) | (pop & empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            latency_q <= '0;
            env_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            latency_q <= latency_d;
            env_bad_q <= env_bad_d;
        end
    end

    assign state     = state_q;
    assign pass      = (state_q == PASS);
    assign fail      = ((state_q == FAIL_DATA) || (state_q == FAIL_TO)) && !env_bad_q;
    assign fail_code = fail_code_of(state_q);
    assign env_bad   = env_bad_q;
    assign latency   = latency_q;

endmodule
`default_nettype wire

// File: doc/integrity_monitor.md
Name: integrity_monitor

Overview:
- Downstream consumer of the data-integrity scoreboard: watches the magic-packet lifecycle around the FIFO and turns the per-cycle prop_signal / data_out_vld pair into sticky pass/fail verdicts.
- Adds a bounded-latency (timeout) check and an environment-legality check, so formal runs and simulation benches read one verdict instead of raw per-cycle signals.
- Sits beside the scoreboard and the FIFO and taps the same push/pop/start/full/empty nets.

Parameters:
- DEPTH, 8, FIFO depth; used only for the occupancy sanity limit.
- TIMEOUT, 64, maximum cycles from magic-packet capture to its exit.
- TOWID, $clog2(TIMEOUT+1), width of the latency timer.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  magic-packet select, same net as the scoreboard's start.
- push  input  1  FIFO push.
- pop  input  1  FIFO pop.
- full  input  1  FIFO full.
- empty  input  1  FIFO empty.
- data_out_vld  input  1  scoreboard: magic packet exiting this cycle.
- prop_signal  input  1  scoreboard: 1 unless exiting data mismatches the magic packet.
- state  output  3  current FSM state encoding (package constant).
- pass  output  1  sticky: magic packet exited with matching data.
- fail  output  1  sticky: data mismatch or timeout, gated by env_bad.
- fail_code  output  2  0 none, 1 data mismatch, 2 timeout.
- env_bad  output  1  sticky: illegal environment stimulus seen.
- latency  output  TOWID  cycles from capture to exit, frozen at the verdict.

Behaviour:
- Reset: rst=1 at a posedge puts the FSM in IDLE and clears pass, fail, fail_code, env_bad, latency and the timer on that edge. This holds regardless of current state, including mid-TRACK.
- States: IDLE, TRACK, PASS, FAIL_DATA, FAIL_TO. All outputs are registered or decoded from registered state, so every verdict appears 1 cycle after the causing input cycle.
- IDLE -> TRACK on start & push (the capture cycle); the timer loads 0. data_out_vld is ignored while in IDLE.
- TRACK, every cycle: the timer increments and saturates at TIMEOUT. Transitions, in priority order:
  - data_out_vld & prop_signal -> PASS.
  - data_out_vld & ~prop_signal -> FAIL_DATA.
  - timer == TIMEOUT and no data_out_vld -> FAIL_TO.
- data_out_vld therefore beats timeout in the same cycle.
- latency: on leaving TRACK, latency <= timer+1 (saturating at TIMEOUT).
- Terminal states PASS, FAIL_DATA and FAIL_TO are sticky until rst. Further start, push or data_out_vld in these states is ignored.
- Decodes:
  - pass = (state==PASS).
  - fail = (state==FAIL_DATA | state==FAIL_TO) & ~env_bad.
  - fail_code follows state and is not gated.
- env_bad: set on (push & full & ~pop) or (pop & empty). It is sticky in every state, including IDLE and the terminal states, and is cleared only by rst. A simultaneous push+pop when full is legal.
- A start without push is a no-op. A second start & push while in TRACK is a no-op, because the magic packet is captured once.

Optional Feature:
- Macro: IMON_TIMEOUT_EN.
- Defined: FAIL_TO is reachable as described, and fail_code=2 is possible.
- Undefined: the FAIL_TO state and transition are compiled out. TRACK waits indefinitely, the timer still saturates at TIMEOUT, and latency reports the saturated value if exit is late.

Decomposition:
- Shared package integrity_pkg holds:
  - FSM state constants (3-bit): IDLE=0, TRACK=1, PASS=2, FAIL_DATA=3, FAIL_TO=4.
  - fail_code constants: FC_NONE, FC_DATA, FC_TIMEOUT.
- One natural sub-module: sat_counter, parameterised by width and max, with clear and enable inputs; it implements the latency timer.

Test Plan:
- rst, then start&push at cycle 2, pop each cycle, data_out_vld=1/prop_signal=1 at cycle 5 -> cycle 6: pass=1, fail=0, fail_code=0, latency=3.
- Capture at cycle 2, data_out_vld=1/prop_signal=0 at cycle 4 -> cycle 5: fail=1, fail_code=1, state=FAIL_DATA; later rst -> IDLE, all outputs 0.
- TIMEOUT=8, capture, never pop, IMON_TIMEOUT_EN defined -> fail=1, fail_code=2, latency=8 exactly 9 cycles after the capture edge. With the macro undefined -> state stays TRACK, latency holds 8.
- pop while empty in IDLE, then a data-mismatch exit -> env_bad=1, state=FAIL_DATA, fail=0, fail_code=1.
- push&pop while full -> env_bad stays 0. Exit with data_out_vld in the same cycle the timer reaches TIMEOUT -> PASS, not FAIL_TO.
- rst asserted mid-TRACK at timer=5 -> next cycle state=IDLE, timer=0; a new capture restarts latency from 0.
